// File: rtl/mem_ctrl_if.sv
// Signal bundle between the pipeline (IF fetch, MEM stage), the shared byte-wide RAM port
// and the memory controller. The controller connects through the slave modport.
interface mem_ctrl_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [2:0]  mem_nbytes;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    modport master (
        output if_req, if_addr, mem_load, mem_store, mem_addr, mem_nbytes, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
    );

    modport slave (
        input  if_req, if_addr, mem_load, mem_store, mem_addr, mem_nbytes, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one 8-bit synchronous RAM port between IF and MEM:
// arbitrates, splits 1-4 byte accesses into RAM cycles and assembles little-endian read data.
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t      r_state, w_state_next;
    owner_t      r_owner;
    logic [31:0] r_addr, r_wdata, r_buf, r_if_data, r_mem_rdata;
    logic [2:0]  r_n, r_k;
    logic [7:0]  r_hold;
    logic        r_held;

    logic        w_take_mem;
    logic [2:0]  w_mem_n;
    logic [1:0]  w_km1;
    logic [7:0]  w_din;
    logic [31:0] w_addr_k, w_buf_next;

    assign w_take_mem = bus.mem_store | bus.mem_load;
    assign w_mem_n    = (bus.mem_nbytes > 3'd4) ? 3'd4 : bus.mem_nbytes;
    assign w_addr_k   = r_addr + {29'd0, r_k};
    assign w_km1      = r_k[1:0] - 2'd1;
    assign w_din      = r_held ? r_hold : bus.ram_din;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)      r_state <= S_IDLE;
        else if (rdy) r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        w_state_next = r_state;
        w_buf_next   = r_buf;
        bus.ram_a    = '0;
        bus.ram_dout = '0;
        bus.ram_wr   = 1'b0;
        bus.if_done  = 1'b0;
        bus.mem_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.mem_store)     w_state_next = (w_mem_n == 3'd0) ? S_DONE : S_WRITE;
                else if (bus.mem_load) w_state_next = (w_mem_n == 3'd0) ? S_DONE : S_READ;
                else if (bus.if_req)   w_state_next = S_READ;
            end
            S_READ: begin
                if (r_k < r_n)     bus.ram_a = w_addr_k;
                if (r_k != 3'd0)   w_buf_next[{w_km1, 3'b000} +: 8] = w_din;
                if (r_k == r_n)    w_state_next = S_DONE;
            end
            S_WRITE: begin
                bus.ram_a    = w_addr_k;
                bus.ram_dout = r_wdata[{r_k[1:0], 3'b000} +: 8];
                bus.ram_wr   = rdy;
                if (r_k == r_n - 3'd1) w_state_next = S_DONE;
            end
            S_DONE: begin
                bus.if_done  = (r_owner == OWN_IF);
                bus.mem_done = (r_owner == OWN_MEM);
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= OWN_IF;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_hold      <= '0;
            r_held      <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
        end else if (!rdy) begin
            // The RAM keeps answering during a stall; keep the byte owed to the pending read.
            if (!r_held) begin
                r_hold <= bus.ram_din;
                r_held <= 1'b1;
            end
        end else begin
            r_held <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take_mem || bus.if_req) begin
                        r_owner <= w_take_mem ? OWN_MEM : OWN_IF;
                        r_addr  <= w_take_mem ? bus.mem_addr : bus.if_addr;
                        r_n     <= w_take_mem ? w_mem_n : 3'd4;
                        r_wdata <= bus.mem_wdata;
                        r_k     <= '0;
                        r_buf   <= '0;
                        if (w_take_mem && w_mem_n == 3'd0) r_mem_rdata <= '0;
                    end
                end
                S_READ: begin
                    r_buf <= w_buf_next;
                    r_k   <= r_k + 3'd1;
                    if (r_k == r_n) begin
                        if (r_owner == OWN_IF) r_if_data   <= w_buf_next;
                        else                   r_mem_rdata <= w_buf_next;
                    end
                end
                S_WRITE: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == r_n - 3'd1) r_mem_rdata <= r_buf;
                end
                default: ;
            endcase
        end
    end

    assign bus.if_data   = r_if_data;
    assign bus.mem_rdata = r_mem_rdata;
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller that shares the single 8-bit synchronous RAM port between instruction fetch (IF) and the memory stage (MEM). It arbitrates between the two requesters, splits each 1-4 byte access into per-byte RAM cycles, and assembles little-endian read data. It sits between the pipeline front-end/MEM stage and the RAM/IO bus. It performs no sign extension, which the MEM stage applies to the returned data.

## Interface
- No parameters; address width 32, data width 32, RAM data width 8.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state
- if_req  in  1  IF fetch request (always 4 bytes), level, held until if_done
- if_addr  in  32  fetch byte address
- if_data  out  32  fetched word, valid with if_done, held until next if_done
- if_done  out  1  one-cycle completion pulse for IF
- mem_load  in  1  MEM load request, level, held until mem_done
- mem_store  in  1  MEM store request, level, held until mem_done
- mem_addr  in  32  load/store byte address
- mem_nbytes  in  3  access size in bytes
- mem_wdata  in  32  store data; byte k = mem_wdata[8k+7:8k]
- mem_rdata  out  32  load data, zero-extended, valid with mem_done, held until next mem_done
- mem_done  out  1  one-cycle completion pulse for MEM
- ram_din  in  8  RAM read byte, valid the cycle after ram_a is presented
- ram_dout  out  8  RAM write byte
- ram_a  out  32  RAM byte address
- ram_wr  out  1  1 = write ram_dout to ram_a at this edge

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Owner register is IF or MEM. Registers hold the latched address A, size n, write data, byte counter k, and an assembly buffer.
- IDLE: the request is sampled here only. Priority is mem_store > mem_load > if_req. On accept, latch owner, A, n (IF: n=4), clear buffer and k, then go to READ (load or fetch) or WRITE (store).
- Size decode: mem_nbytes 1..4 used literally; 5..7 treated as 4. A size of 0 goes IDLE->DONE with no RAM cycle and mem_rdata=0.
- READ, cycle with counter k (0..n): if k<n, ram_a=A+k. If k>=1, buffer[8(k-1)+7:8(k-1)] <= ram_din. k increments. The k==n cycle latches the last byte and then goes to DONE.
- WRITE, cycle k (0..n-1): ram_wr=1, ram_a=A+k, ram_dout=wdata byte k. After k==n-1, go to DONE.
- DONE (one cycle): pulse the owner's done. Drive the owner's data output from the buffer, with unread upper bytes 0. Return to IDLE.
- No preemption. A transaction in progress always completes before the other requester is considered.
- A+k wraps modulo 2^32.
- Illegal input handling: if mem_load and mem_store are both high, the store wins. Request inputs are sampled only at acceptance; later changes are ignored until DONE.

## Timing
- Reset values: state IDLE, if_done=0, mem_done=0, if_data=0, mem_rdata=0, ram_a=0, ram_dout=0, ram_wr=0. Any in-flight access is abandoned. Bytes already written stay written.
- Outside READ/WRITE: ram_wr=0 and ram_a=0.
- Read latency: request accepted in IDLE cycle c, READ in cycles c+1..c+n+1, done in cycle c+n+2. A 4-byte fetch or LW therefore gets done 6 cycles after acceptance.
- Write latency: WRITE in cycles c+1..c+n, done in cycle c+n+1.
- Handshake: the requester deasserts its request on the edge that ends its done cycle. A request still high in the following IDLE cycle is treated as a new access.
- Back-to-back: IDLE occurs for at least one cycle between transactions. The minimum turnaround from done to next acceptance is 1 cycle.
- Simultaneous if_req and mem_load in IDLE: MEM is served first. IF is accepted in the IDLE cycle after mem_done if if_req is still high.
- rdy=0: state, counter, buffer and outputs are held; ram_wr is forced 0; done pulses are extended until rdy returns. rst overrides rdy.

## Test plan
- Fetch: RAM[0x100..0x103]=0x13,0x05,0x00,0x00; if_req, if_addr=0x100 -> ram_a 0x100..0x103 on consecutive cycles; if_done 6 cycles after acceptance; if_data=0x00000513.
- Contention: if_req and mem_load (nbytes=1, addr=0x200, RAM=0xF0) raised together -> mem_done first with mem_rdata=0x000000F0, no ram_a=if_addr before it; IF then completes normally.
- Store: mem_store, addr=0x1000, nbytes=2, wdata=0xAABBCCDD -> ram_wr=1 for 2 cycles with (0x1000,0xDD) then (0x1001,0xCC); mem_done next cycle; RAM[0x1002] untouched.
- Wrap and size clamp: mem_load addr=0xFFFFFFFE, nbytes=7 -> ram_a FFFFFFFE, FFFFFFFF, 00000000, 00000001; 4 bytes returned.
- rdy low for 3 cycles mid-READ, then rst mid-WRITE -> no byte lost or duplicated across the stall; after rst, ram_wr=0, state IDLE, no done pulse, next request served cleanly.
